watch_mode_ctrl: RTL and testbench
==================================

// Module: watch_mode_ctrl
// PURPOSE
//  Front-panel controller for the digital watch. Debounces three raw buttons and runs the mode FSM.
//  Sequences the stopwatch block with one-cycle Start_S/Stop_S/Reset_S pulses and drives its Control display select.
//  Issues hour/minute increment pulses to the timekeeping block while in a set mode.
//  Sits between the board pins and the clock, stopwatch and display blocks.
// PARAMETERS
//  DEBOUNCE_MS      20    cycles a synced button must hold a new level before the debounced level follows
//  REPEAT_DELAY_MS  500   hold time of A in a set mode before auto-repeat starts
//  REPEAT_RATE_MS   200   auto-repeat period after the delay
//  IDLE_TIMEOUT_MS  10000 cycles without any press in a set mode before forced return to CLOCK
//  BLINK_HALF_MS    500   half-period of Set_Blink
// PORTS
//  Clock_1MSec  in   1  1 kHz system clock; all logic on its rising edge
//  Reset        in   1  synchronous reset, active-high
//  Btn_Mode     in   1  raw mode button, active-high, asynchronous to the clock
//  Btn_A        in   1  raw action button A (start/stop, increment)
//  Btn_B        in   1  raw action button B (reset, exit set)
//  Start_S      out  1  one-cycle pulse: stopwatch start
//  Stop_S       out  1  one-cycle pulse: stopwatch stop
//  Reset_S      out  1  one-cycle pulse: stopwatch clear
//  Control      out  1  display select: 1 = stopwatch digits, 0 = time-of-day digits
//  Mode         out  2  current FSM state (watch_pkg encoding)
//  Inc_Hour     out  1  one-cycle pulse: timekeeper hours +1
//  Inc_Min      out  1  one-cycle pulse: timekeeper minutes +1
//  Sw_Running   out  1  1 while the stopwatch has been started and not stopped
//  Set_Blink    out  1  blink enable for the field being set
// BEHAVIOUR
//  Reset: every output 0, Mode=CLOCK. Sync flops, debounce, repeat, idle and blink counters cleared.
//   Reset issues no Reset_S pulse; the stopwatch has its own reset.
//  Input path: 2-flop synchroniser, then debounce. Debounced level changes after DEBOUNCE_MS consecutive equal samples.
//   Press = rising edge of the debounced level, one cycle wide.
//   A raw rise first sampled in cycle N gives a press pulse in cycle N+2+DEBOUNCE_MS. Shorter glitches give nothing.
//  Actions are registered: an output pulse is high in the cycle after the press pulse.
//  FSM states: CLOCK=0, STOPWATCH=1, SET_HOUR=2, SET_MIN=3.
//   Mode press: CLOCK->STOPWATCH->SET_HOUR->SET_MIN->CLOCK.
//   CLOCK: A and B ignored.
//   STOPWATCH:
//    A press with Sw_Running=0: Start_S pulse, Sw_Running<=1.
//    A press with Sw_Running=1: Stop_S pulse, Sw_Running<=0.
//    B press with Sw_Running=0: Reset_S pulse.
//    B press with Sw_Running=1: ignored.
//   SET_HOUR: A press -> Inc_Hour pulse. SET_MIN: A press -> Inc_Min pulse. B press in either -> CLOCK, no pulse.
//  Control=1 only in STOPWATCH.
//  Sw_Running persists across mode changes; the stopwatch keeps counting while another mode is displayed.
//  Auto-repeat, set modes only:
//   With debounced A held, repeat pulses start REPEAT_DELAY_MS after the press, then every REPEAT_RATE_MS.
//   Each repeat acts like an A press. The counter clears on release or on any mode change.
//  Idle timeout, set modes only:
//   The counter clears on any press or repeat. On reaching IDLE_TIMEOUT_MS: Mode<=CLOCK, no pulse.
//   It is held at 0 outside the set modes.
//  Set_Blink: toggles every BLINK_HALF_MS in SET_HOUR/SET_MIN, starting at 1 on entry. It is 0 in other modes.
//  Simultaneous presses in one cycle: Mode beats A beats B. Only the winner acts; losers are dropped, not queued.
//  At most one of Start_S/Stop_S/Reset_S/Inc_Hour/Inc_Min is high in any cycle.
//  Counter widths: $clog2(param+1). Counters saturate, never wrap.
//  Reset asserted mid-operation: back to the reset state at the next edge; a pending action pulse is suppressed.
// STRUCTURE
//  watch_pkg: mode enum (CLOCK/STOPWATCH/SET_HOUR/SET_MIN), 2-bit mode width, default ms constants.
//  Sub-module btn_debounce (DEBOUNCE_MS): synchroniser, debounce counter, level and press outputs.
//   Instantiated 3 times. FSM, repeat, idle and blink logic live in the top module.
// TESTING (DEBOUNCE_MS=4, REPEAT_DELAY_MS=20, REPEAT_RATE_MS=10, IDLE_TIMEOUT_MS=100, BLINK_HALF_MS=8)
//  1. Reset high 3 cycles, then low -> all outputs 0, Mode=0. Btn_A 3-cycle glitch -> no press, no pulse.
//  2. Mode press, then A press -> Mode=1, Control=1, Start_S 1 cycle, Sw_Running=1.
//     Then B press -> no Reset_S. Then A press -> Stop_S. Then B press -> Reset_S 1 cycle.
//  3. Stopwatch running, then 3 Mode presses -> Mode 2, 3, 0 and Control=0, with Sw_Running still 1.
//     Then 1 Mode press -> Mode=1, Control=1.
//  4. SET_HOUR, hold A 45 cycles past the press -> Inc_Hour at press+1, then +20, +30, +40 (4 pulses).
//     Release A -> repeats stop.
//  5. SET_MIN, no input 100 cycles -> Mode=0 and Set_Blink=0. Blink period in set mode measured as 16 cycles.
//  6. Mode and A presses in the same cycle while in STOPWATCH -> Mode=2, no Start_S.
//     Reset asserted the cycle after an A press -> no pulse appears.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared mode encoding and default timing constants for the watch front-panel controller.
package watch_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        CLOCK     = 2'd0,
        STOPWATCH = 2'd1,
        SET_HOUR  = 2'd2,
        SET_MIN   = 2'd3
    } mode_e;

    localparam int DEF_DEBOUNCE_MS     = 20;
    localparam int DEF_REPEAT_DELAY_MS = 500;
    localparam int DEF_REPEAT_RATE_MS  = 200;
    localparam int DEF_IDLE_TIMEOUT_MS = 10000;
    localparam int DEF_BLINK_HALF_MS   = 500;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            CLOCK:     next_mode = STOPWATCH;
            STOPWATCH: next_mode = SET_HOUR;
            SET_HOUR:  next_mode = SET_MIN;
            default:   next_mode = CLOCK;
        endcase
    endfunction

    function automatic logic is_set_mode(input mode_e m);
        is_set_mode = (m == SET_HOUR) || (m == SET_MIN);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus a counting debouncer; emits the clean level and a
// one-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample agreeing with the current level restarts the run count.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Front-panel controller: debounced buttons drive the mode FSM, stopwatch
// start/stop/clear pulses, set-mode increments with auto-repeat, idle exit and blink.
module watch_mode_ctrl
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
    parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS,
    parameter int IDLE_TIMEOUT_MS = DEF_IDLE_TIMEOUT_MS,
    parameter int BLINK_HALF_MS   = DEF_BLINK_HALF_MS
) (
    input  logic       Clock_1MSec,
    input  logic       Reset,
    input  logic       Btn_Mode,
    input  logic       Btn_A,
    input  logic       Btn_B,
    output logic       Start_S,
    output logic       Stop_S,
    output logic       Reset_S,
    output logic       Control,
    output logic [1:0] Mode,
    output logic       Inc_Hour,
    output logic       Inc_Min,
    output logic       Sw_Running,
    output logic       Set_Blink
);

    localparam int RPT_W = $clog2(REPEAT_DELAY_MS + 1);
    localparam int IDL_W = $clog2(IDLE_TIMEOUT_MS + 1);
    localparam int BLK_W = $clog2(BLINK_HALF_MS + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY_MS);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS + 1);
    localparam logic [IDL_W-1:0] IDLE_MAX   = IDL_W'(IDLE_TIMEOUT_MS);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_HALF_MS - 1);

    logic mode_press, a_press, b_press, a_level;
    logic mode_level_unused, b_level_unused;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_mode (
        .clk(Clock_1MSec), .rst(Reset), .btn_raw(Btn_Mode),
        .level(mode_level_unused), .press(mode_press));
    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_a (
        .clk(Clock_1MSec), .rst(Reset), .btn_raw(Btn_A),
        .level(a_level), .press(a_press));
    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_b (
        .clk(Clock_1MSec), .rst(Reset), .btn_raw(Btn_B),
        .level(b_level_unused), .press(b_press));

    mode_e            mode_q, mode_d;
    logic             start_q, start_d, stop_q, stop_d, clr_q, clr_d;
    logic             inc_hour_q, inc_hour_d, inc_min_q, inc_min_d;
    logic             control_q, control_d, running_q, running_d, blink_q, blink_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [IDL_W-1:0] idle_q, idle_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             in_set, rpt_fire, a_evt, any_evt;

    always_comb begin
        in_set   = is_set_mode(mode_q);
        rpt_fire = in_set && a_level && (rpt_q == RPT_DELAY);
        a_evt    = a_press || rpt_fire;
        any_evt  = mode_press || a_evt || b_press;

        mode_d     = mode_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        clr_d      = 1'b0;
        inc_hour_d = 1'b0;
        inc_min_d  = 1'b0;
        running_d  = running_q;

        // Priority Mode > A > B; a losing press in the same cycle is simply dropped.
        if (mode_press) begin
            mode_d = next_mode(mode_q);
        end else if (a_evt) begin
            case (mode_q)
                STOPWATCH: begin
                    start_d   = !running_q;
                    stop_d    = running_q;
                    running_d = !running_q;
                end
                SET_HOUR: inc_hour_d = 1'b1;
                SET_MIN:  inc_min_d  = 1'b1;
                default:  ;
            endcase
        end else if (b_press) begin
            if (mode_q == STOPWATCH) clr_d = !running_q;
            else if (in_set)         mode_d = CLOCK;
        end else if (in_set && idle_q == IDLE_MAX) begin
            mode_d = CLOCK;
        end

        control_d = (mode_d == STOPWATCH);

        if (!in_set || !a_level || mode_d != mode_q) rpt_d = '0;
        else if (a_press)                            rpt_d = RPT_W'(1);
        else if (rpt_fire)                           rpt_d = RPT_RELOAD;
        else if (rpt_q != '0)                        rpt_d = rpt_q + 1'b1;
        else                                         rpt_d = rpt_q;

        if (!in_set || any_evt || mode_d != mode_q) idle_d = '0;
        else if (idle_q != IDLE_MAX)                idle_d = idle_q + 1'b1;
        else                                        idle_d = idle_q;

        // Blink restarts high on every entry into a set mode, including SET_HOUR -> SET_MIN.
        blink_d = blink_q;
        blk_d   = '0;
        if (!is_set_mode(mode_d))    blink_d = 1'b0;
        else if (mode_d != mode_q)   blink_d = 1'b1;
        else if (blk_q == BLINK_LAST) blink_d = !blink_q;
        else                         blk_d = blk_q + 1'b1;
    end

    always_ff @(posedge Clock_1MSec) begin
        if (Reset) begin
            mode_q     <= CLOCK;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            clr_q      <= 1'b0;
            inc_hour_q <= 1'b0;
            inc_min_q  <= 1'b0;
            control_q  <= 1'b0;
            running_q  <= 1'b0;
            blink_q    <= 1'b0;
            rpt_q      <= '0;
            idle_q     <= '0;
            blk_q      <= '0;
        end else begin
            mode_q     <= mode_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            clr_q      <= clr_d;
            inc_hour_q <= inc_hour_d;
            inc_min_q  <= inc_min_d;
            control_q  <= control_d;
            running_q  <= running_d;
            blink_q    <= blink_d;
            rpt_q      <= rpt_d;
            idle_q     <= idle_d;
            blk_q      <= blk_d;
        end
    end

    assign Mode       = mode_q;
    assign Start_S    = start_q;
    assign Stop_S     = stop_q;
    assign Reset_S    = clr_q;
    assign Inc_Hour   = inc_hour_q;
    assign Inc_Min    = inc_min_q;
    assign Control    = control_q;
    assign Sw_Running = running_q;
    assign Set_Blink  = blink_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench for watch_mode_ctrl with short timing parameters; outputs are
// sampled on the falling edge, buttons change on the falling edge.
module tb_watch_mode_ctrl;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Btn_Mode = 1'b0, Btn_A = 1'b0, Btn_B = 1'b0;
    logic       Start_S, Stop_S, Reset_S, Control, Inc_Hour, Inc_Min, Sw_Running, Set_Blink;
    logic [1:0] Mode;

    int vec_cnt = 0;
    int err_cnt = 0;

    watch_mode_ctrl #(
        .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(20), .REPEAT_RATE_MS(10),
        .IDLE_TIMEOUT_MS(100), .BLINK_HALF_MS(8)
    ) dut (
        .Clock_1MSec(clk), .Reset(Reset),
        .Btn_Mode(Btn_Mode), .Btn_A(Btn_A), .Btn_B(Btn_B),
        .Start_S(Start_S), .Stop_S(Stop_S), .Reset_S(Reset_S), .Control(Control),
        .Mode(Mode), .Inc_Hour(Inc_Hour), .Inc_Min(Inc_Min),
        .Sw_Running(Sw_Running), .Set_Blink(Set_Blink)
    );

    always #5 clk = ~clk;

    // {Start_S, Stop_S, Reset_S, Inc_Hour, Inc_Min}
    logic [4:0] pulses;
    // {Start_S, Stop_S, Reset_S, Control, Mode, Inc_Hour, Inc_Min, Sw_Running, Set_Blink}
    logic [9:0] all_outs;
    assign pulses   = {Start_S, Stop_S, Reset_S, Inc_Hour, Inc_Min};
    assign all_outs = {Start_S, Stop_S, Reset_S, Control, Mode, Inc_Hour, Inc_Min, Sw_Running, Set_Blink};

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raw rise sampled at the next edge: press pulse 6 samples later, action one cycle after.
    task automatic press(input logic m, input logic a, input logic b);
        Btn_Mode = m;
        Btn_A    = a;
        Btn_B    = b;
        tick(7);
    endtask

    task automatic release_all();
        Btn_Mode = 1'b0;
        Btn_A    = 1'b0;
        Btn_B    = 1'b0;
        tick(10);
    endtask

    initial begin
        logic [4:0] seen;
        int         hits[$];
        int         rises[$];
        int         other;
        logic       prev_blink;
        int         exp_hits[4];
        logic [15:0] obs;

        // 1. reset, then a 3-cycle glitch on A
        tick(3);
        Reset = 1'b0;
        tick(1);
        check("reset_outputs", 16'(all_outs), 16'h0);
        Btn_A = 1'b1;
        tick(3);
        Btn_A = 1'b0;
        seen = '0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            seen |= pulses;
        end
        check("glitch_no_pulse", 16'(seen), 16'h0);
        check("glitch_mode", 16'(Mode), 16'd0);

        // 2. stopwatch start / ignored clear / stop / clear
        press(1'b1, 1'b0, 1'b0);
        check("sw_enter_mode_ctl", 16'({Mode, Control}), 16'({2'd1, 1'b1}));
        release_all();
        press(1'b0, 1'b1, 1'b0);
        check("start_pulse_run", 16'({pulses, Sw_Running}), 16'({5'b10000, 1'b1}));
        tick(1);
        check("start_one_cycle", 16'(pulses), 16'h0);
        release_all();
        Btn_B = 1'b1;
        seen = '0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            seen |= pulses;
        end
        check("b_ignored_running", 16'(seen), 16'h0);
        release_all();
        press(1'b0, 1'b1, 1'b0);
        check("stop_pulse_run", 16'({pulses, Sw_Running}), 16'({5'b01000, 1'b0}));
        release_all();
        press(1'b0, 1'b0, 1'b1);
        check("clear_pulse", 16'(pulses), 16'(5'b00100));
        tick(1);
        check("clear_one_cycle", 16'(pulses), 16'h0);
        release_all();

        // 3. running stopwatch survives a full mode cycle
        press(1'b0, 1'b1, 1'b0);
        check("restart_run", 16'({pulses, Sw_Running}), 16'({5'b10000, 1'b1}));
        release_all();
        press(1'b1, 1'b0, 1'b0);
        check("to_set_hour", 16'({Mode, Control}), 16'({2'd2, 1'b0}));
        release_all();
        press(1'b1, 1'b0, 1'b0);
        check("to_set_min", 16'({Mode, Control}), 16'({2'd3, 1'b0}));
        release_all();
        press(1'b1, 1'b0, 1'b0);
        check("to_clock_running", 16'({Mode, Control, Sw_Running}), 16'({2'd0, 1'b0, 1'b1}));
        release_all();
        press(1'b1, 1'b0, 1'b0);
        check("back_to_sw", 16'({Mode, Control}), 16'({2'd1, 1'b1}));
        release_all();

        // 4. SET_HOUR auto-repeat: pulses 7, 27, 37, 47 samples after raw press
        press(1'b1, 1'b0, 1'b0);
        check("set_hour_blink", 16'({Mode, Set_Blink}), 16'({2'd2, 1'b1}));
        release_all();
        Btn_A = 1'b1;
        other = 0;
        for (int k = 1; k <= 70; k++) begin
            tick(1);
            if (Inc_Hour) hits.push_back(k);
            if (Inc_Min || Start_S || Stop_S || Reset_S) other++;
            if (k == 45) Btn_A = 1'b0;
        end
        check("repeat_count", 16'(hits.size()), 16'd4);
        exp_hits = '{7, 27, 37, 47};
        for (int i = 0; i < 4; i++) begin
            obs = (i < hits.size()) ? 16'(hits[i]) : 16'hffff;
            check($sformatf("repeat_at_%0d", i), obs, 16'(exp_hits[i]));
        end
        check("repeat_no_other", 16'(other), 16'd0);

        // 5. SET_MIN blink period and idle timeout
        press(1'b1, 1'b0, 1'b0);
        check("set_min_blink", 16'({Mode, Set_Blink}), 16'({2'd3, 1'b1}));
        Btn_Mode = 1'b0;
        prev_blink = Set_Blink;
        for (int k = 8; k <= 107; k++) begin
            tick(1);
            if (Set_Blink && !prev_blink) rises.push_back(k);
            prev_blink = Set_Blink;
        end
        obs = (rises.size() > 0) ? 16'(rises[0]) : 16'hffff;
        check("blink_first_rise", obs, 16'd23);
        obs = (rises.size() > 1) ? 16'(rises[1] - rises[0]) : 16'hffff;
        check("blink_period", obs, 16'd16);
        check("idle_not_yet", 16'(Mode), 16'd3);
        tick(1);
        check("idle_timeout", 16'({Mode, Set_Blink, pulses}), 16'({2'd0, 1'b0, 5'b0}));

        // 6. Mode beats A in the same cycle; reset kills a pending pulse
        press(1'b1, 1'b0, 1'b0);
        check("sw_again", 16'(Mode), 16'd1);
        release_all();
        press(1'b0, 1'b1, 1'b0);
        check("stop_before_tie", 16'({pulses, Sw_Running}), 16'({5'b01000, 1'b0}));
        release_all();
        press(1'b1, 1'b1, 1'b0);
        check("mode_beats_a", 16'({Mode, pulses, Sw_Running}), 16'({2'd2, 5'b0, 1'b0}));
        tick(1);
        check("mode_beats_a_late", 16'(pulses), 16'h0);
        release_all();
        Btn_A = 1'b1;
        tick(6);
        Reset = 1'b1;
        tick(1);
        check("reset_suppress", 16'(all_outs), 16'h0);
        Reset = 1'b0;
        Btn_A = 1'b0;
        seen = '0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            seen |= pulses;
        end
        check("after_reset_quiet", 16'({seen, Mode}), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
